arbiter_rr_param: RTL and testbench

- Parametrised successor of the 4-in/4-out routing arbiter between the input FIFO bank and the output FIFO bank.
- Pops one word per cycle from a non-empty input FIFO. Destination comes from the head word's MSBs. Pushes the word to the destination output FIFO one cycle later.
- Adds three things the 4-channel version lacks: selectable fixed-priority or round-robin arbitration, a selectable backpressure policy (global stall or per-destination skip), and saturating per-output push counters.

---
 rtl/arb_pkg.sv | 28 ++
 rtl/rr_select.sv | 54 +++++
 rtl/arbiter_rr_param.sv | 127 ++++++++++++
 tb/tb_arbiter_rr_param.sv | 351 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/arb_pkg.sv
// Shared definitions for the parametrised routing arbiter: FSM encoding,
// default sizes and compile-time width helpers.
package arb_pkg;

  typedef enum logic [1:0] {
    RESET  = 2'b00,
    IDLE   = 2'b01,
    ACTIVE = 2'b10
  } arb_state_t;

  localparam int N_IN_DEF  = 4;
  localparam int N_OUT_DEF = 4;
  localparam int DW_DEF    = 6;

  // Ceiling log2; 0 for v <= 1.
  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction

  // Index width that never collapses to zero bits.
  function automatic int idx_w(input int n);
    return (n > 1) ? clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_select.sv
// N-way picker: fixed priority (index 0 highest) or round robin starting at
// i_ptr. Returns a one-hot grant, its index and a valid flag.
module rr_select
  import arb_pkg::*;
#(
  parameter int N       = N_IN_DEF,
  parameter int RR_MODE = 1,
  parameter int IW      = idx_w(N)
) (
  input  logic [N-1:0]  i_eligible,
  input  logic [IW-1:0] i_ptr,
  output logic [N-1:0]  o_grant,
  output logic [IW-1:0] o_idx,
  output logic          o_valid
);

  localparam int SW = IW + 1;

  logic [IW-1:0] w_base;
  logic [IW-1:0] w_cand [N];
  logic [N-1:0]  w_rot;
  logic          w_found;
  logic [IW-1:0] w_idx;

  assign w_base = (RR_MODE != 0) ? i_ptr : '0;

  // Search order: position gi holds channel (base + gi) mod N.
  for (genvar gi = 0; gi < N; gi++) begin : g_rot
    logic [SW-1:0] w_sum;
    assign w_sum       = {1'b0, w_base} + SW'(gi);
    assign w_cand[gi]  = (w_sum >= SW'(N)) ? IW'(w_sum - SW'(N)) : w_sum[IW-1:0];
    assign w_rot[gi]   = i_eligible[w_cand[gi]];
  end

  always_comb begin
    w_found = 1'b0;
    w_idx   = '0;
    for (int k = 0; k < N; k++) begin
      if (!w_found && w_rot[k]) begin
        w_found = 1'b1;
        w_idx   = w_cand[k];
      end
    end
  end

  always_comb begin
    o_grant = '0;
    if (w_found) o_grant[w_idx] = 1'b1;
  end

  assign o_idx   = w_idx;
  assign o_valid = w_found;

endmodule

// File: rtl/arbiter_rr_param.sv
// Parametrised routing arbiter: pops one head word per cycle from the input
// FIFO bank and pushes it one cycle later to the output FIFO named by its MSBs.
module arbiter_rr_param
  import arb_pkg::*;
#(
  parameter int N_IN      = N_IN_DEF,
  parameter int N_OUT     = N_OUT_DEF,
  parameter int DW        = DW_DEF,
  parameter int DEST_W    = clog2(N_OUT),
  parameter int RR_MODE   = 1,
  parameter int SKIP_MODE = 1,
  parameter int CW        = 8
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [N_IN-1:0]     empty,
  input  logic [N_IN*DW-1:0]  data_in,
  input  logic [N_OUT-1:0]    afull,
  output logic [N_IN-1:0]     pop,
  output logic [N_OUT-1:0]    push,
  output logic [DW-1:0]       data_out,
  output logic [N_OUT*CW-1:0] push_cnt,
  output logic                idle
);

  localparam int IW = idx_w(N_IN);

  arb_state_t       r_state;
  logic             r_idle;
  logic [N_OUT-1:0] r_push;
  logic [DW-1:0]    r_data;
  logic [IW-1:0]    r_ptr;

  logic [N_IN-1:0]   w_eligible;
  logic [N_IN-1:0]   w_grant;
  logic [IW-1:0]     w_gidx;
  logic              w_gvalid;
  logic              w_run;
  logic              w_fire;
  logic [DW-1:0]     w_word;
  logic [DEST_W-1:0] w_dest;
  logic [N_OUT-1:0]  w_push_next;
  logic [IW-1:0]     w_ptr_next;

  // A channel competes only if it has a word and the output it needs can take it.
  for (genvar gi = 0; gi < N_IN; gi++) begin : g_elig
    if (SKIP_MODE != 0) begin : g_skip
      logic [DEST_W-1:0] w_head_dest;
      assign w_head_dest    = data_in[gi*DW + DW - DEST_W +: DEST_W];
      assign w_eligible[gi] = !empty[gi] && !afull[w_head_dest];
    end else begin : g_stall
      logic w_any_afull;
      assign w_any_afull    = |afull;
      assign w_eligible[gi] = !empty[gi] && !w_any_afull;
    end
  end

  rr_select #(
    .N       (N_IN),
    .RR_MODE (RR_MODE),
    .IW      (IW)
  ) u_sel (
    .i_eligible (w_eligible),
    .i_ptr      (r_ptr),
    .o_grant    (w_grant),
    .o_idx      (w_gidx),
    .o_valid    (w_gvalid)
  );

  // No grant while reset is held or during the first cycle after release.
  assign w_run  = reset && (r_state != RESET);
  assign w_fire = w_run && w_gvalid;
  assign pop    = w_run ? w_grant : '0;

  assign w_word      = data_in[w_gidx*DW +: DW];
  assign w_dest      = w_word[DW-1 -: DEST_W];
  assign w_push_next = w_fire ? (N_OUT'(1) << w_dest) : '0;
  assign w_ptr_next  = (w_gidx == IW'(N_IN - 1)) ? '0 : w_gidx + 1'b1;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= RESET;
      r_idle  <= 1'b0;
      r_push  <= '0;
      r_data  <= '0;
      r_ptr   <= '0;
    end else begin
      case (r_state)
        RESET: begin
          r_state <= IDLE;
          r_idle  <= 1'b1;
        end
        IDLE, ACTIVE: begin
          r_state <= w_gvalid ? ACTIVE : IDLE;
          r_idle  <= !w_gvalid;
        end
        default: begin
          r_state <= RESET;
          r_idle  <= 1'b0;
        end
      endcase
      r_push <= w_push_next;
      if (w_fire) begin
        r_data <= w_word;
        r_ptr  <= w_ptr_next;
      end
    end
  end

  // Counters advance on the same edge that raises the matching push bit.
  for (genvar gi = 0; gi < N_OUT; gi++) begin : g_cnt
    logic [CW-1:0] r_cnt;
    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        r_cnt <= '0;
      end else if (w_push_next[gi] && (r_cnt != {CW{1'b1}})) begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
    assign push_cnt[gi*CW +: CW] = r_cnt;
  end

  assign push     = r_push;
  assign data_out = r_data;
  assign idle     = r_idle;

endmodule

// File: tb/tb_arbiter_rr_param.sv
// Four arbiter configurations share one stimulus bus and are checked against
// a behavioural model of the grant, push, counter and idle rules.
module tb_arbiter_rr_param;

  logic        clk     = 1'b0;
  logic        rst_n   = 1'b1;
  logic [3:0]  empty   = 4'hF;
  logic [23:0] data_in = '0;
  logic [3:0]  afull   = '0;

  // dut 0: rr+skip, 1: fixed+skip, 2: rr+stall, 3: rr+skip with 2-bit counters
  logic [3:0] o_pop  [4];
  logic [3:0] o_push [4];
  logic [5:0] o_data [4];
  logic [7:0] o_cnt  [4][4];
  logic       o_idle [4];

  int checks   = 0;
  int failures = 0;

  int         m_ptr   [4];
  bit         m_fresh [4];
  logic [3:0] m_push  [4];
  logic [5:0] m_data  [4];
  int         m_cnt   [4][4];
  bit         m_idle  [4];

  always #5 clk = ~clk;

  for (genvar gc = 0; gc < 4; gc++) begin : g_dut
    localparam int CWI = (gc == 3) ? 2 : 8;
    logic [4*CWI-1:0] cnt_w;
    arbiter_rr_param #(
      .N_IN(4), .N_OUT(4), .DW(6), .DEST_W(2),
      .RR_MODE((gc == 1) ? 0 : 1),
      .SKIP_MODE((gc == 2) ? 0 : 1),
      .CW(CWI)
    ) u_dut (
      .clk      (clk),
      .reset    (rst_n),
      .empty    (empty),
      .data_in  (data_in),
      .afull    (afull),
      .pop      (o_pop[gc]),
      .push     (o_push[gc]),
      .data_out (o_data[gc]),
      .push_cnt (cnt_w),
      .idle     (o_idle[gc])
    );
    for (genvar gd = 0; gd < 4; gd++) begin : g_cnt
      assign o_cnt[gc][gd] = 8'(cnt_w[gd*CWI +: CWI]);
    end
  end

  function automatic bit cfg_rr(input int c);   return c != 1; endfunction
  function automatic bit cfg_skip(input int c); return c != 2; endfunction
  function automatic int cfg_max(input int c);  return (c == 3) ? 3 : 255; endfunction

  function automatic logic [5:0] hw(input int dest, input int pay);
    return {2'(dest), 4'(pay)};
  endfunction

  // Winner under the written rules: scan channels in priority order, first eligible wins.
  function automatic int model_grant(input int c);
    int         start;
    int         ch;
    int         d;
    logic [5:0] w;
    if (!rst_n || m_fresh[c]) return -1;
    start = cfg_rr(c) ? m_ptr[c] : 0;
    for (int k = 0; k < 4; k++) begin
      ch = (start + k) % 4;
      w  = data_in[ch*6 +: 6];
      d  = int'(w[5:4]);
      if (!empty[ch] && (cfg_skip(c) ? !afull[d] : (afull == 4'b0))) return ch;
    end
    return -1;
  endfunction

  function automatic logic [3:0] pred_pop(input int c);
    int g;
    g = model_grant(c);
    return (g < 0) ? 4'b0 : 4'(1 << g);
  endfunction

  task automatic model_reset();
    for (int c = 0; c < 4; c++) begin
      m_ptr[c] = 0; m_fresh[c] = 1'b1; m_push[c] = '0; m_data[c] = '0; m_idle[c] = 1'b0;
      for (int d = 0; d < 4; d++) m_cnt[c][d] = 0;
    end
  endtask

  task automatic model_edge();
    int g;
    int d;
    if (!rst_n) return;
    for (int c = 0; c < 4; c++) begin
      g = model_grant(c);
      if (g >= 0) begin
        m_data[c] = data_in[g*6 +: 6];
        d         = int'(m_data[c][5:4]);
        m_push[c] = 4'(1 << d);
        m_ptr[c]  = (g + 1) % 4;
        if (m_cnt[c][d] < cfg_max(c)) m_cnt[c][d]++;
      end else begin
        m_push[c] = '0;
      end
      m_idle[c]  = m_fresh[c] ? 1'b1 : (g < 0);
      m_fresh[c] = 1'b0;
    end
  endtask

  task automatic clk_edge();
    @(posedge clk);
    #1;
    model_edge();
  endtask

  task automatic test_reset();
    rst_n = 1'b0; empty = 4'hF; data_in = '0; afull = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    for (int c = 0; c < 4; c++) begin
      checks++;
      if (o_push[c] !== 4'b0 || o_data[c] !== 6'b0 || o_idle[c] !== 1'b0 || o_pop[c] !== 4'b0) begin
        failures++;
        $display("FAIL reset_state dut=%0d push=%b data=%h idle=%b pop=%b required all zero",
                 c, o_push[c], o_data[c], o_idle[c], o_pop[c]);
      end
    end
    for (int cyc = 0; cyc < 5; cyc++) begin
      @(negedge clk);
      if (cyc == 0) rst_n = 1'b1;
      empty = 4'hF;
      #1;
      for (int c = 0; c < 4; c++) begin
        checks++;
        if (o_pop[c] !== 4'b0) begin
          failures++;
          $display("FAIL reset_pop dut=%0d cyc=%0d pop=%b required 0000", c, cyc, o_pop[c]);
        end
      end
      clk_edge();
      for (int c = 0; c < 4; c++) begin
        checks++;
        if (o_push[c] !== 4'b0 || o_idle[c] !== 1'b1) begin
          failures++;
          $display("FAIL reset_idle dut=%0d cyc=%0d push=%b idle=%b required 0000/1", c, cyc, o_push[c], o_idle[c]);
        end
      end
    end
    for (int c = 0; c < 4; c++)
      for (int d = 0; d < 4; d++) begin
        checks++;
        if (o_cnt[c][d] !== 8'd0) begin
          failures++;
          $display("FAIL reset_cnt dut=%0d dest=%0d cnt=%0d required 0", c, d, o_cnt[c][d]);
        end
      end
  endtask

  task automatic test_rr_order();
    logic [3:0] exp_push [5];
    exp_push = '{4'b0100, 4'b0001, 4'b1000, 4'b0010, 4'b0100};
    for (int cyc = 0; cyc < 5; cyc++) begin
      @(negedge clk);
      empty = 4'b0; afull = 4'b0;
      data_in = {hw(1, 3), hw(3, 12), hw(0, 5), hw(2, 10)};
      #1;
      checks++;
      if (o_pop[0] !== 4'(1 << (cyc % 4))) begin
        failures++;
        $display("FAIL rr_pop cyc=%0d pop=%b required %b", cyc, o_pop[0], 4'(1 << (cyc % 4)));
      end
      clk_edge();
      checks++;
      if (o_push[0] !== exp_push[cyc] || o_data[0] !== m_data[0]) begin
        failures++;
        $display("FAIL rr_push cyc=%0d push=%b data=%h required %b/%h", cyc, o_push[0], o_data[0], exp_push[cyc], m_data[0]);
      end
    end
  endtask

  task automatic test_fixed();
    for (int cyc = 0; cyc < 5; cyc++) begin
      @(negedge clk);
      empty = 4'b0; afull = 4'b0;
      data_in = {hw(1, 3), hw(3, 12), hw(0, 5), hw(2, 10)};
      #1;
      checks++;
      if (o_pop[1] !== 4'b0001) begin
        failures++;
        $display("FAIL fixed_pop cyc=%0d pop=%b required 0001", cyc, o_pop[1]);
      end
      clk_edge();
      checks++;
      if (o_push[1] !== 4'b0100 || o_cnt[1][2] !== 8'(m_cnt[1][2])) begin
        failures++;
        $display("FAIL fixed_push cyc=%0d push=%b cnt2=%0d required 0100/%0d", cyc, o_push[1], o_cnt[1][2], m_cnt[1][2]);
      end
    end
  endtask

  task automatic test_skip();
    for (int cyc = 0; cyc < 4; cyc++) begin
      @(negedge clk);
      empty = 4'b1100; afull = 4'b0001;
      data_in = {hw(1, 1), hw(1, 2), hw(2, 7), hw(0, 9)};
      #1;
      checks++;
      if (o_pop[0] !== 4'b0010 || o_pop[2] !== 4'b0000) begin
        failures++;
        $display("FAIL skip_pop cyc=%0d skip_pop=%b stall_pop=%b required 0010/0000", cyc, o_pop[0], o_pop[2]);
      end
      clk_edge();
      checks++;
      if (o_push[0] !== 4'b0100 || o_push[2] !== 4'b0000) begin
        failures++;
        $display("FAIL skip_push cyc=%0d skip_push=%b stall_push=%b required 0100/0000", cyc, o_push[0], o_push[2]);
      end
    end
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    empty = 4'b1011; afull = 4'b0;
    data_in = {hw(0, 3), hw(1, 9), hw(0, 2), hw(0, 1)};
    #1;
    clk_edge();
    checks++;
    if (o_push[0] !== 4'b0010) begin
      failures++;
      $display("FAIL mid_setup push=%b required 0010", o_push[0]);
    end
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    for (int c = 0; c < 4; c++) begin
      checks++;
      if (o_push[c] !== 4'b0 || o_data[c] !== 6'b0 || o_pop[c] !== 4'b0) begin
        failures++;
        $display("FAIL mid_reset dut=%0d push=%b data=%h pop=%b required zero", c, o_push[c], o_data[c], o_pop[c]);
      end
    end
    for (int cyc = 0; cyc < 2; cyc++) begin
      @(negedge clk);
      if (cyc == 0) rst_n = 1'b1;
      empty = 4'b0;
      data_in = {hw(1, 3), hw(3, 12), hw(0, 5), hw(2, 10)};
      #1;
      checks++;
      if (o_pop[0] !== ((cyc == 0) ? 4'b0000 : 4'b0001)) begin
        failures++;
        $display("FAIL mid_regrant cyc=%0d pop=%b required %b", cyc, o_pop[0], (cyc == 0) ? 4'b0000 : 4'b0001);
      end
      clk_edge();
    end
    checks++;
    if (o_push[0] !== 4'b0100 || o_data[0] !== hw(2, 10)) begin
      failures++;
      $display("FAIL mid_push push=%b data=%h required 0100/%h", o_push[0], o_data[0], hw(2, 10));
    end
  endtask

  task automatic test_saturate();
    int exp_cnt;
    @(negedge clk);
    rst_n = 1'b0;
    model_reset();
    for (int cyc = 0; cyc < 7; cyc++) begin
      @(negedge clk);
      if (cyc == 0) rst_n = 1'b1;
      empty = 4'b1101; afull = 4'b0;
      data_in = {hw(0, 0), hw(0, 0), hw(3, cyc), hw(0, 0)};
      #1;
      checks++;
      if (o_pop[3] !== ((cyc == 0) ? 4'b0000 : 4'b0010)) begin
        failures++;
        $display("FAIL sat_pop cyc=%0d pop=%b required %b", cyc, o_pop[3], (cyc == 0) ? 4'b0000 : 4'b0010);
      end
      clk_edge();
      exp_cnt = (cyc == 0) ? 0 : ((cyc > 3) ? 3 : cyc);
      checks++;
      if (o_cnt[3][3] !== 8'(exp_cnt) || o_push[3] !== ((cyc == 0) ? 4'b0000 : 4'b1000)) begin
        failures++;
        $display("FAIL sat_cnt cyc=%0d cnt3=%0d push=%b required %0d", cyc, o_cnt[3][3], o_push[3], exp_cnt);
      end
    end
  endtask

  task automatic test_random();
    for (int cyc = 0; cyc < 400; cyc++) begin
      @(negedge clk);
      if (!rst_n) begin
        rst_n = 1'b1;
      end else if ($urandom_range(0, 39) == 0) begin
        rst_n = 1'b0;
        model_reset();
      end
      empty   = 4'($urandom) & 4'($urandom);
      data_in = 24'($urandom);
      afull   = ($urandom_range(0, 2) == 0) ? 4'($urandom) : 4'b0;
      #1;
      for (int c = 0; c < 4; c++) begin
        checks++;
        if (o_pop[c] !== pred_pop(c)) begin
          failures++;
          $display("FAIL rand_pop dut=%0d cyc=%0d pop=%b required %b", c, cyc, o_pop[c], pred_pop(c));
        end
      end
      clk_edge();
      for (int c = 0; c < 4; c++) begin
        checks++;
        if (o_push[c] !== m_push[c] || o_data[c] !== m_data[c] || o_idle[c] !== m_idle[c]) begin
          failures++;
          $display("FAIL rand_out dut=%0d cyc=%0d push=%b data=%h idle=%b required %b/%h/%b",
                   c, cyc, o_push[c], o_data[c], o_idle[c], m_push[c], m_data[c], m_idle[c]);
        end
        for (int d = 0; d < 4; d++) begin
          checks++;
          if (o_cnt[c][d] !== 8'(m_cnt[c][d])) begin
            failures++;
            $display("FAIL rand_cnt dut=%0d cyc=%0d dest=%0d cnt=%0d required %0d", c, cyc, d, o_cnt[c][d], m_cnt[c][d]);
          end
        end
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    #1;
    test_reset();
    test_rr_order();
    test_fixed();
    test_skip();
    test_reset_mid();
    test_saturate();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
